restoring_divider: RTL and testbench

// - Sequential shift-subtract (restoring) unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.
// - Inverse of the shift-add multiplier datapath: AQ register shifts left, trial-subtracts divisor M each step.
// - Sits beside the multiplier in the lab arithmetic unit.
// - Driven by a start pulse; results are held until the next start.

---
 rtl/divider_pkg.sv | 19 +
 rtl/div_trial_sub.sv | 17 +
 rtl/restoring_divider.sv | 165 ++++++++++++++++
 tb/tb_restoring_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

    // Default divisor/quotient/remainder width; the dividend is twice this.
    localparam int DEFAULT_N = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold the iteration count 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor for one restoring-division step.
// The divider's counterpart to the multiplier's adder.
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Widen by one bit so the borrow out of the W-bit difference is explicit.
    always_comb begin
        {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential shift-subtract (restoring) unsigned divider:
// 2N-bit dividend / N-bit divisor -> N-bit quotient and N-bit remainder.
//
// Handshake: start is sampled only in IDLE or DONE; dividend and divisor are
// captured on that same edge. Divide-by-zero and quotient-overflow requests go
// straight to DONE on the start edge; all other requests spend N cycles in ITER
// (busy=1) and then reach DONE. ready=1 exactly while in DONE, and quotient,
// remainder, div_by_zero and overflow are valid and held while ready=1. A start
// accepted in DONE drops ready on that edge unless it is an error request, which
// stays in DONE with fresh results. start during ITER is ignored.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           ready,
    output logic           div_by_zero,
    output logic           overflow,
    output state_t         state_dbg
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        next_state;

    // The partial remainder A is conceptually N+1 bits, but once a step has
    // restored or subtracted it is always below M, so only N bits are stored;
    // the extra bit reappears in the shifted value fed to the subtractor.
    logic [N-1:0]  a_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  m_reg;
    logic [CW-1:0] count;

    logic [N:0]    a_shift;
    logic [N:0]    trial;
    logic          trial_borrow;
    logic          trial_msb_unused;
    logic [N-1:0]  a_next;
    logic [N-1:0]  q_next;
    logic          start_zero;
    logic          start_ovf;
    logic          last_iter;

    assign a_shift    = {a_reg, q_reg[N-1]};
    assign start_zero = (divisor == '0);
    assign start_ovf  = (dividend[2*N-1:N] >= divisor);
    assign last_iter  = (count == LAST);

    div_trial_sub #(
        .W (N + 1)
    ) u_trial_sub (
        .minuend    (a_shift),
        .subtrahend ({1'b0, m_reg}),
        .diff       (trial),
        .borrow     (trial_borrow)
    );

    // A_shifted < 2M always, so a negative trial (MSB set) coincides with the
    // subtractor borrow; the borrow drives the restore decision and the trial
    // MSB is otherwise not needed.
    assign trial_msb_unused = trial[N];

    // One restoring step: keep the shifted A on borrow, else take the trial.
    always_comb begin
        a_next = a_shift[N-1:0];
        q_next = {q_reg[N-2:0], 1'b0};
        if (!trial_borrow) begin
            a_next = trial[N-1:0];
            q_next = {q_reg[N-2:0], 1'b1};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: error requests finish at once, others iterate N times.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = (start_zero || start_ovf) ? DONE : ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result/flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (start_zero) begin
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else if (start_ovf) begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else begin
                            a_reg       <= dividend[2*N-1:N];
                            q_reg       <= dividend[N-1:0];
                            m_reg       <= divisor;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        quotient  <= q_next;
                        remainder <= a_next;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == ITER);
    assign ready     = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (N=4): directed cases, an
// exhaustive operand sweep and randomized requests, scored against / and %.
module tb_restoring_divider;
    import divider_pkg::*;

    localparam int N  = 4;
    localparam int EW = 2 + 2 * N + 8;   // {dz, ov, quotient, remainder, latency}

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           ready;
    logic           div_by_zero;
    logic           overflow;
    state_t         state_dbg;

    int             checks = 0;
    int             errors = 0;
    logic [EW-1:0]  exp_q[$];

    int             edge_cnt = 0;
    int             acc_edge = 0;
    int             busy_cnt = 0;
    bit             prev_ready = 1'b0;
    bit             prev_acc = 1'b0;

    restoring_divider #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // Clock and edge counter.
    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer division; latency counts edges after the start edge.
    function automatic logic [EW-1:0] model(input logic [2*N-1:0] dd, input logic [N-1:0] ds);
        int q, r, lat;
        logic dz, ov;
        dz = 1'b0; ov = 1'b0;
        if (ds == 0) begin
            dz = 1'b1; q = (1 << N) - 1; r = 0; lat = 0;
        end else if (int'(dd) / int'(ds) >= (1 << N)) begin
            ov = 1'b1; q = (1 << N) - 1; r = 0; lat = 0;
        end else begin
            q = int'(dd) / int'(ds); r = int'(dd) % int'(ds); lat = N;
        end
        return {dz, ov, N'(q), N'(r), 8'(lat)};
    endfunction

    // Driver: wait until not busy, present one start pulse.
    task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] ds, input bit push);
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        if (push) exp_q.push_back(model(dd, ds));
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_quot"}, 32'(quotient), 32'd0);
        check({tag, "_rem"}, 32'(remainder), 32'd0);
        check({tag, "_dz"}, 32'(div_by_zero), 32'd0);
        check({tag, "_ov"}, 32'(overflow), 32'd0);
    endtask

    // Monitor: a new result is presented when ready rises, or when ready stays
    // high across an accepted start (error request issued from DONE).
    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (reset) begin
            prev_ready = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (ready && (!prev_ready || prev_acc)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("div_by_zero", 32'(div_by_zero), 32'(e[EW-1]));
                    check("overflow", 32'(overflow), 32'(e[EW-2]));
                    check("quotient", 32'(quotient), 32'(e[2*N+7:N+8]));
                    check("remainder", 32'(remainder), 32'(e[N+7:8]));
                    check("latency", 32'(edge_cnt - acc_edge), 32'(e[7:0]));
                    check("busy_cycles", 32'(busy_cnt), 32'(e[7:0]));
                end
            end
            if (busy) busy_cnt++;
            if (start && !busy) begin
                acc_edge = edge_cnt + 1;
                busy_cnt = 0;
            end
            prev_acc   = start && !busy;
            prev_ready = ready;
        end
    end

    // Stimulus.
    initial begin
        int n;
        int gap;
        logic [N-1:0]   rds;
        logic [2*N-1:0] rdd;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed cases.
        issue(8'h23, 4'h5, 1'b1);
        issue(8'h64, 4'h9, 1'b1);
        issue(8'h2A, 4'h0, 1'b1);
        issue(8'h50, 4'h5, 1'b1);

        // start during ITER is ignored; the 35/5 result must come out.
        issue(8'h23, 4'h5, 1'b1);
        @(posedge clock); #1;
        dividend = 8'h64;
        divisor  = 4'h9;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;

        // Reset at iteration 2 aborts the divide and produces no result.
        issue(8'h23, 4'h5, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("midreset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_cleared("midreset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Exhaustive sweep, back-to-back starts from DONE.
        for (int dd = 0; dd < (1 << (2 * N)); dd++) begin
            for (int ds = 0; ds < (1 << N); ds++) begin
                issue((2*N)'(dd), N'(ds), 1'b1);
            end
        end

        // Randomized requests with random idle gaps, half biased to legal divides.
        repeat (300) begin
            rds = N'($urandom_range(0, (1 << N) - 1));
            rdd = (2*N)'($urandom_range(0, (1 << (2 * N)) - 1));
            if ($urandom_range(0, 1) == 1 && rds != 0) begin
                rdd = {N'($urandom_range(0, int'(rds) - 1)), rdd[N-1:0]};
            end
            issue(rdd, rds, 1'b1);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end

        // Drain outstanding expectations.
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
